multicycle_core_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32I-subset core. It replaces the single-cycle decode-and-execute flow with an FSM that steps a shared datapath (PC, IR, register file, ALU, unified memory) one phase per state. Memory access uses a request/ready handshake with a bounded wait. It also keeps cycle and retired-instruction counters.

---
 rtl/multicycle_core_ctrl_pkg.sv | 50 +++++
 rtl/multicycle_core_ctrl_alu_op_decode.sv | 28 ++
 rtl/multicycle_core_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_multicycle_core_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_core_ctrl_pkg.sv
// Shared encodings for the multi-cycle core sequencer: opcodes, ALU ops,
// FSM states, mux selects and trap causes.
package core_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;

  typedef logic [3:0] state_t;
  localparam state_t S_FETCH      = 4'd0;
  localparam state_t S_FETCH_WAIT = 4'd1;
  localparam state_t S_DECODE     = 4'd2;
  localparam state_t S_EXEC       = 4'd3;
  localparam state_t S_ALU_WB     = 4'd4;
  localparam state_t S_ADDR       = 4'd5;
  localparam state_t S_MEM        = 4'd6;
  localparam state_t S_MEM_WAIT   = 4'd7;
  localparam state_t S_LOAD_WB    = 4'd8;
  localparam state_t S_BRANCH     = 4'd9;
  localparam state_t S_TRAP       = 4'd10;

  localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SRC_TARGET = 2'd1;
  localparam logic [1:0] PC_SRC_HOLD   = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_FOUR = 2'd1;
  localparam logic [1:0] SRC_B_IMM  = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  function automatic logic is_wait(input state_t s);
    return (s == S_FETCH_WAIT) || (s == S_MEM_WAIT);
  endfunction

endpackage

// File: rtl/multicycle_core_ctrl_alu_op_decode.sv
// Combinational ALU operation select for R-type and I-ALU instructions.
module alu_op_decode
  import core_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    if (opcode == OP_R || opcode == OP_I) begin
      case (funct3)
        // addi has no subtract form, so bit 30 is only honoured for R-type
        3'b000:  alu_ctrl = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_ctrl = ALU_SLL;
        3'b010:  alu_ctrl = ALU_SLT;
        3'b011:  alu_ctrl = ALU_SLT;
        3'b100:  alu_ctrl = ALU_XOR;
        3'b101:  alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
        3'b110:  alu_ctrl = ALU_OR;
        default: alu_ctrl = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_core_ctrl.sv
// Multi-cycle sequencer: steps a shared datapath one phase per state, with a
// bounded memory wait, sticky trap, and cycle/instret counters.
module multicycle_core_ctrl
  import core_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_ctrl,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic [XLEN-1:0]  pc_inc,
  output state_t           dbg_state
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               trap_q, trap_d;
  logic [1:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic               retire;
  logic               tmo_hit;
  logic [3:0]         exec_alu_ctrl;

  alu_op_decode u_alu_op_decode (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .alu_ctrl (exec_alu_ctrl)
  );

  // Fires on the MEM_TIMEOUT-th cycle spent in a wait state.
  assign tmo_hit = (MEM_TIMEOUT != 0) && (tmo_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH, S_FETCH_WAIT: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (state_q == S_FETCH_WAIT && tmo_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          state_d = S_FETCH_WAIT;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R, OP_I:         state_d = S_EXEC;
          OP_LOAD, OP_STORE:  state_d = S_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_EXEC:   state_d = S_ALU_WB;
      S_ALU_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_ADDR:   state_d = S_MEM;
      S_MEM, S_MEM_WAIT: begin
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = S_LOAD_WB;
          end
        end else if (state_q == S_MEM_WAIT && tmo_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          state_d = S_MEM_WAIT;
        end
      end
      S_LOAD_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_BRANCH: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase

    trap_d    = trap_q | (state_d == S_TRAP);
    tmo_d     = (is_wait(state_q) && state_d == state_q) ? tmo_q + 1'b1 : '0;
    cycle_d   = cycle_q + 1'b1;
    instret_d = retire ? instret_q + 1'b1 : instret_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      tmo_q     <= '0;
      trap_q    <= 1'b0;
      cause_q   <= CAUSE_NONE;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  // Strobes are gated by reset so a mid-access reset withdraws mem_req at once.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = PC_SRC_HOLD;
    ir_write   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_RS2;
    alu_ctrl   = ALU_AND;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    if (reset) begin
      case (state_q)
        S_FETCH, S_FETCH_WAIT: begin
          mem_req   = 1'b1;
          alu_src_b = SRC_B_FOUR;
          alu_ctrl  = ALU_ADD;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_SRC_PLUS4;
          end
        end
        S_DECODE: begin
          alu_src_b = SRC_B_IMM;
          alu_ctrl  = ALU_ADD;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = (opcode == OP_I) ? SRC_B_IMM : SRC_B_RS2;
          alu_ctrl  = exec_alu_ctrl;
        end
        S_ALU_WB: reg_write = 1'b1;
        S_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRC_B_IMM;
          alu_ctrl  = ALU_ADD;
        end
        S_MEM, S_MEM_WAIT: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = (opcode == OP_STORE);
        end
        S_LOAD_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_src_b = SRC_B_RS2;
          alu_ctrl  = ALU_SUB;
          if ((funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero)) begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_TARGET;
          end
        end
        default: ;
      endcase
    end
  end

  assign trap        = trap_q;
  assign trap_cause  = cause_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
  assign pc_inc      = XLEN'(4);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_multicycle_core_ctrl.sv
// Directed bench for multicycle_core_ctrl with hand-computed expectations.
module tb_multicycle_core_ctrl;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        funct7b5 = 1'b0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, ir_write, mem_req, mem_we, iord, alu_src_a;
  logic        reg_write, mem_to_reg, trap;
  logic [1:0]  pc_src, alu_src_b, trap_cause;
  logic [3:0]  alu_ctrl;
  logic [31:0] cycle_cnt, instret_cnt, pc_inc;
  state_t      dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int req_cycles;

  multicycle_core_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .trap(trap),
    .trap_cause(trap_cause), .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt), .pc_inc(pc_inc), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mem_ready = 1'b0;
    zero = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", dbg_state, S_FETCH);
    check("rst_mem_req", mem_req, 0);
    check("rst_pc_src", pc_src, 2);
    check("rst_alu_b", alu_src_b, 0);
    check("rst_trap", {trap, trap_cause}, 0);
    check("rst_cycle", cycle_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic f7, input logic [3:0] exp_ctrl, input logic [1:0] exp_b,
                         input int exp_instret);
    opcode = op; funct3 = f3; funct7b5 = f7; mem_ready = 1'b1;
    #1;
    check({tag, "_fetch"}, {dbg_state, ir_write, pc_write, pc_src, mem_req},
          {S_FETCH, 1'b1, 1'b1, 2'd0, 1'b1});
    check({tag, "_fetch_alu"}, {alu_src_a, alu_src_b, alu_ctrl}, {1'b0, 2'd1, ALU_ADD});
    step(); #1;
    check({tag, "_decode"}, {dbg_state, alu_src_a, alu_src_b, alu_ctrl, mem_req},
          {S_DECODE, 1'b0, 2'd2, ALU_ADD, 1'b0});
    step(); #1;
    check({tag, "_exec"}, {dbg_state, alu_src_a, alu_src_b, alu_ctrl},
          {S_EXEC, 1'b1, exp_b, exp_ctrl});
    step(); #1;
    check({tag, "_wb"}, {dbg_state, reg_write, mem_to_reg}, {S_ALU_WB, 1'b1, 1'b0});
    step(); #1;
    check({tag, "_instret"}, instret_cnt, exp_instret);
  endtask

  initial begin
    // ALU instructions, memory always ready
    do_reset();
    check("pc_inc", pc_inc, 4);
    run_alu("add", OP_R, 3'b000, 1'b0, ALU_ADD, 2'd0, 1);
    check("add_cycles", cycle_cnt, 4);
    run_alu("sub", OP_R, 3'b000, 1'b1, ALU_SUB, 2'd0, 2);
    run_alu("sra", OP_R, 3'b101, 1'b1, ALU_SRA, 2'd0, 3);
    run_alu("xor", OP_R, 3'b100, 1'b0, ALU_XOR, 2'd0, 4);
    run_alu("addi", OP_I, 3'b000, 1'b1, ALU_ADD, 2'd2, 5);
    run_alu("srai", OP_I, 3'b101, 1'b1, ALU_SRA, 2'd2, 6);
    run_alu("ori", OP_I, 3'b110, 1'b0, ALU_OR, 2'd2, 7);
    check("alu_cycles", cycle_cnt, 28);

    // Load with three wait cycles, then a store
    do_reset();
    opcode = OP_LOAD; mem_ready = 1'b1;
    step(); step(); #1;
    check("ld_addr", {dbg_state, alu_src_a, alu_src_b, alu_ctrl}, {S_ADDR, 1'b1, 2'd2, ALU_ADD});
    mem_ready = 1'b0;
    step();
    req_cycles = 0;
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3);
      #1;
      if (mem_req) req_cycles++;
      check($sformatf("ld_mem%0d", k), {dbg_state, iord, mem_we},
            {(k == 0) ? S_MEM : S_MEM_WAIT, 1'b1, 1'b0});
      step();
    end
    #1;
    check("ld_req_cycles", req_cycles, 4);
    check("ld_wb", {dbg_state, reg_write, mem_to_reg, mem_req}, {S_LOAD_WB, 1'b1, 1'b1, 1'b0});
    step(); #1;
    check("ld_instret", instret_cnt, 1);
    opcode = OP_STORE; mem_ready = 1'b1;
    step(); step(); step(); #1;
    check("st_mem", {dbg_state, mem_req, iord, mem_we}, {S_MEM, 1'b1, 1'b1, 1'b1});
    step(); #1;
    check("st_retire", {dbg_state, instret_cnt}, {S_FETCH, 32'd2});

    // Async reset while waiting on a load
    opcode = OP_LOAD; mem_ready = 1'b1;
    step(); step(); mem_ready = 1'b0; step(); step(); #1;
    check("ar_wait", {dbg_state, mem_req}, {S_MEM_WAIT, 1'b1});
    reset = 1'b0;
    #1;
    check("ar_req", {dbg_state, mem_req}, {S_FETCH, 1'b0});
    check("ar_cnt", {cycle_cnt, instret_cnt}, 64'd0);

    // Branches: beq taken, bne not taken, then an illegal funct3
    do_reset();
    opcode = OP_BRANCH; funct3 = 3'b000; zero = 1'b1; mem_ready = 1'b1;
    step(); step(); #1;
    check("beq", {dbg_state, pc_write, pc_src, alu_src_a, alu_src_b, alu_ctrl},
          {S_BRANCH, 1'b1, 2'd1, 1'b1, 2'd0, ALU_SUB});
    step(); funct3 = 3'b001;
    step(); step(); #1;
    check("bne", {dbg_state, pc_write, pc_src}, {S_BRANCH, 1'b0, 2'd2});
    step(); #1;
    check("br_instret", instret_cnt, 2);
    funct3 = 3'b100;
    step(); step(); step(); #1;
    check("br_bad", {dbg_state, trap, trap_cause, instret_cnt}, {S_TRAP, 1'b1, 2'd1, 32'd2});

    // Illegal opcode: trap sticks, cycle_cnt runs, instret frozen
    do_reset();
    opcode = 7'b1111111; mem_ready = 1'b1;
    step(); step(); #1;
    check("ill_trap", {dbg_state, trap, trap_cause}, {S_TRAP, 1'b1, 2'd1});
    check("ill_cycle0", cycle_cnt, 2);
    repeat (5) step();
    #1;
    check("ill_cycle1", cycle_cnt, 7);
    check("ill_frozen", {instret_cnt, trap, mem_req, reg_write, pc_write}, {32'd0, 1'b1, 3'b000});

    // Fetch timeout after 15 wait cycles
    do_reset();
    opcode = OP_R; funct3 = 3'b000; mem_ready = 1'b0;
    #1;
    check("to_fetch", {ir_write, pc_write, pc_src, mem_req}, {1'b0, 1'b0, 2'd2, 1'b1});
    step();
    for (int i = 0; i < 15; i++) begin
      #1;
      check($sformatf("to_wait%0d", i), {dbg_state, mem_req, trap}, {S_FETCH_WAIT, 1'b1, 1'b0});
      step();
    end
    #1;
    check("to_trap", {dbg_state, trap, trap_cause, mem_req}, {S_TRAP, 1'b1, 2'd2, 1'b0});

    // mem_ready on the 15th wait cycle wins over the timeout
    do_reset();
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 14; i++) step();
    mem_ready = 1'b1;
    #1;
    check("lim_ready", {dbg_state, ir_write, pc_write}, {S_FETCH_WAIT, 1'b1, 1'b1});
    step(); #1;
    check("lim_decode", {dbg_state, trap, trap_cause}, {S_DECODE, 1'b0, 2'd0});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
